// File: rtl/fan_tach_meter.sv
// Fan tach reader: 2-flop sync, FILTER_LEN-tick glitch filter, ticks per revolution, stall flag.
// Latency FILTER_LEN ticks + 1 clk_i, no backpressure; define TACH_AVG_EN for 2^AVG_LOG2-revolution block averaging.
module fan_tach_meter #(
    parameter int unsigned CNT_BITWIDTH   = 20,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned PULSES_PER_REV = 2,
    parameter int unsigned STALL_TICKS    = 500000,
    parameter int unsigned AVG_LOG2       = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic                    tach_i,
    output logic [CNT_BITWIDTH-1:0] period_o,
    output logic                    valid_o,
    output logic                    stall_o,
    output logic                    tach_filt_o
);

    localparam int unsigned W  = CNT_BITWIDTH;
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned PW = (PULSES_PER_REV > 1) ? $clog2(PULSES_PER_REV) : 1;
    localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [PW-1:0] PC_LAST    = PW'(PULSES_PER_REV - 1);
    localparam logic [W-1:0]  STALL_LAST = W'(STALL_TICKS - 1);
    localparam logic [W-1:0]  CNT_MAX    = '1;

    typedef enum logic {SYNC, MEASURE} state_t;
    state_t state_q, state_d;

    logic          sync1_q, sync2_q;
    logic [FW-1:0] filt_cnt_q;
    logic [W-1:0]  ivl_q, rev_q;
    logic [PW-1:0] pc_q;

    logic          filt_diff, filt_flip, rise;
    logic [W:0]    ivl_inc, rev_sum;
    logic [W-1:0]  interval, rev_total;
    logic          capture, stall_hit;

    always_comb begin
        filt_diff = (sync2_q != tach_filt_o);
        filt_flip = clk_en_i && filt_diff && (filt_cnt_q == FILT_LAST);
        rise      = filt_flip && !tach_filt_o;
        // the edge itself counts as a tick, so edges T ticks apart measure T
        ivl_inc   = {1'b0, ivl_q} + 1'b1;
        interval  = ivl_inc[W] ? CNT_MAX : ivl_inc[W-1:0];
        rev_sum   = {1'b0, rev_q} + {1'b0, interval};
        rev_total = rev_sum[W] ? CNT_MAX : rev_sum[W-1:0];

        state_d   = state_q;
        capture   = 1'b0;
        stall_hit = 1'b0;
        case (state_q)
            SYNC: begin
                if (rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    capture = (pc_q == PC_LAST);
                end else if (clk_en_i && ivl_q == STALL_LAST) begin
                    stall_hit = 1'b1;
                    state_d   = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SYNC;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= tach_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_cnt_q  <= '0;
            tach_filt_o <= 1'b0;
        end else if (clk_en_i) begin
            if (!filt_diff) begin
                filt_cnt_q <= '0;
            end else if (filt_flip) begin
                filt_cnt_q  <= '0;
                tach_filt_o <= ~tach_filt_o;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ivl_q <= '0;
            rev_q <= '0;
            pc_q  <= '0;
        end else if (clk_en_i) begin
            if (rise) begin
                ivl_q <= '0;
                if (state_q == SYNC || capture) begin
                    rev_q <= '0;
                    pc_q  <= '0;
                end else begin
                    rev_q <= rev_total;
                    pc_q  <= pc_q + 1'b1;
                end
            end else if (stall_hit) begin
                ivl_q <= '0;
                rev_q <= '0;
                pc_q  <= '0;
            end else if (ivl_q != CNT_MAX) begin
                ivl_q <= ivl_q + 1'b1;
            end
        end
    end

`ifdef TACH_AVG_EN
    localparam int unsigned AW = W + AVG_LOG2;
    localparam int unsigned CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] AVG_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc_q, acc_sum, avg_wide;
    logic [CW-1:0] acc_cnt_q;
    logic [W-1:0]  avg_sat;
    logic          avg_pub;

    always_comb begin
        acc_sum  = acc_q + AW'(rev_total);
        avg_wide = acc_sum >> AVG_LOG2;
        avg_sat  = (avg_wide > AW'(CNT_MAX)) ? CNT_MAX : avg_wide[W-1:0];
        avg_pub  = capture && (acc_cnt_q == AVG_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || stall_hit) begin
            acc_q     <= '0;
            acc_cnt_q <= '0;
        end else if (capture) begin
            if (avg_pub) begin
                acc_q     <= '0;
                acc_cnt_q <= '0;
            end else begin
                acc_q     <= acc_sum;
                acc_cnt_q <= acc_cnt_q + 1'b1;
            end
        end
    end
`else
    logic [W-1:0] avg_sat;
    logic         avg_pub;
    logic         avg_unused;

    always_comb begin
        avg_sat = rev_total;
        avg_pub = capture;
    end
    assign avg_unused = (AVG_LOG2 != 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_o <= '0;
            valid_o  <= 1'b0;
            stall_o  <= 1'b1;
        end else begin
            valid_o <= 1'b0;
            if (stall_hit) begin
                period_o <= CNT_MAX;
                valid_o  <= 1'b1;
                stall_o  <= 1'b1;
            end else if (avg_pub) begin
                period_o <= avg_sat;
                valid_o  <= 1'b1;
                stall_o  <= 1'b0;
            end
        end
    end

endmodule
